step_clock_gen: RTL

Generates the processor clock for board demos from the 100 MHz board clock and two raw board inputs.
- Step mode: one debounced push-button press produces exactly one clean, fixed-width clock pulse.
- Run mode: a slide switch selects a free-running divided clock.
- Sits directly upstream of the top-level demo wrapper: cpu_clk drives the pipelined processor's clock input.
- step_count can be routed to the 4-digit SSD scanner for cycle tracking.

---
 rtl/step_clock_gen_pkg.sv | 25 ++
 rtl/debounce_sync.sv | 58 +++++
 rtl/step_clock_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/step_clock_gen_pkg.sv
// Shared definitions for the step/run demo clock generator.
//   - FSM state encoding (3-bit)
//   - default parameter values for the top and the input conditioner
//   - counter width helper
package step_clock_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_STEP_HI       = 3'd1,
    ST_STEP_WAIT_REL = 3'd2,
    ST_RUN_LO        = 3'd3,
    ST_RUN_HI        = 3'd4
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;  // 10 ms at 100 MHz
  localparam int DEF_PULSE_CYCLES    = 4;
  localparam int DEF_RUN_HALF        = 25000000; // 2 Hz run clock at 100 MHz
  localparam int DEF_CNT_W           = 16;       // default width of step_count

  // Bits needed to hold the values 0 .. max_val-1 (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Input conditioner for one raw asynchronous board input.
//   clk    : board clock
//   reset  : synchronous, active-high
//   din    : raw asynchronous input
//   dout   : synchronized, debounced level
// A 2-flop synchronizer feeds a debouncer that only accepts a new level once
// it has been seen for DEBOUNCE_CYCLES consecutive cycles. Total latency from
// a stable raw change to dout is 2 + DEBOUNCE_CYCLES cycles.
module debounce_sync
  import step_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synced input agrees with the accepted level restarts
  // the stability window, so only an unbroken run of the new level counts.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/step_clock_gen.sv
// Processor clock source for board demos.
//   clk        : 100 MHz board clock (single domain, posedge)
//   reset      : synchronous, active-high
//   btn_step   : raw step push-button, active-high
//   sw_run     : raw mode switch, 1 = free-running, 0 = single step
//   cpu_clk    : registered clock to the processor
//   step_count : number of cpu_clk rising edges since reset (wraps)
//   run_active : high while the generator is in its run states
// Step mode emits one PULSE_CYCLES-wide pulse per debounced press; run mode
// emits a 50% duty clock with a period of 2*RUN_HALF board cycles.
module step_clock_gen
  import step_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int RUN_HALF        = DEF_RUN_HALF,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             sw_run,
  output logic             cpu_clk,
  output logic [CNT_W-1:0] step_count,
  output logic             run_active
);

  localparam int PH_MAX = (PULSE_CYCLES > RUN_HALF) ? PULSE_CYCLES : RUN_HALF;
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(RUN_HALF - 1);

  logic btn_db, run_db;
  logic btn_db_prev_q;
  logic btn_rise;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             cpu_clk_q, run_active_q;
  logic [CNT_W-1:0] step_count_q;
  logic             enter_hi;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (clk),
    .reset (reset),
    .din   (btn_step),
    .dout  (btn_db)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .din   (sw_run),
    .dout  (run_db)
  );

  assign btn_rise = btn_db & ~btn_db_prev_q;

  // Presses are only acted on in IDLE; a rise seen elsewhere is dropped.
  // STEP_WAIT_REL holds until release so a held button gives one pulse.
  // A mode change during RUN_HI is deferred to the end of RUN_LO so the
  // high phase always completes at full width.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_db)        state_d = ST_RUN_LO;
        else if (btn_rise) state_d = ST_STEP_HI;
      end
      ST_STEP_HI: begin
        if (phase_q == PULSE_LAST) state_d = ST_STEP_WAIT_REL;
      end
      ST_STEP_WAIT_REL: begin
        if (!btn_db) state_d = ST_IDLE;
      end
      ST_RUN_LO: begin
        if (phase_q == HALF_LAST) state_d = run_db ? ST_RUN_HI : ST_IDLE;
      end
      ST_RUN_HI: begin
        if (phase_q == HALF_LAST) state_d = ST_RUN_LO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign phase_d  = (state_d != state_q) ? '0 : phase_q + 1'b1;
  assign enter_hi = (state_d != state_q) &&
                    ((state_d == ST_STEP_HI) || (state_d == ST_RUN_HI));

  // Outputs are decoded from the next state so cpu_clk and run_active change
  // on the same edge as the state register, with no combinational path out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      cpu_clk_q     <= 1'b0;
      run_active_q  <= 1'b0;
      step_count_q  <= '0;
      btn_db_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cpu_clk_q     <= (state_d == ST_STEP_HI) || (state_d == ST_RUN_HI);
      run_active_q  <= (state_d == ST_RUN_LO) || (state_d == ST_RUN_HI);
      btn_db_prev_q <= btn_db;
      if (enter_hi) step_count_q <= step_count_q + 1'b1;
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign run_active = run_active_q;
  assign step_count = step_count_q;

endmodule
